// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch front end.
// Issues imem reads at the current PC, computes the next PC, buffers returned
// words in order and hands them to decode with a valid/ready handshake.
// Redirects from execute flush the buffer and squash in-flight responses.
// Optional build macro: FETCH_PERF_EN adds stall/flush performance counters.
module fetch_unit #(
  parameter int unsigned       ADDR_W    = 16,
  parameter int unsigned       DATA_W    = 16,
  parameter int unsigned       BUF_DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] next_pc,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              imem_req_valid,
  output logic [ADDR_W-1:0] imem_req_addr,
  input  logic              imem_req_ready,
  input  logic              imem_resp_valid,
  input  logic [DATA_W-1:0] imem_resp_data,
  output logic              inst_valid,
  output logic [DATA_W-1:0] inst_data,
  output logic [ADDR_W-1:0] inst_pc,
  input  logic              inst_ready
`ifdef FETCH_PERF_EN
  ,
  output logic [15:0]       perf_stall_cycles,
  output logic [15:0]       perf_flushes
`endif
);

  localparam int unsigned PTR_W = $clog2(BUF_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned SUM_W = CNT_W + 1;

  // Outstanding request addresses, oldest first
  logic [ADDR_W-1:0] afifo_q [BUF_DEPTH];
  logic [PTR_W-1:0]  af_wr_q, af_wr_d;
  logic [PTR_W-1:0]  af_rd_q, af_rd_d;

  // Instruction buffer entries {addr, data}
  logic [ADDR_W-1:0] buf_addr_q [BUF_DEPTH];
  logic [DATA_W-1:0] buf_data_q [BUF_DEPTH];
  logic [PTR_W-1:0]  bf_wr_q, bf_wr_d;
  logic [PTR_W-1:0]  bf_rd_q, bf_rd_d;

  logic [CNT_W-1:0]  count_q, count_d;
  logic [CNT_W-1:0]  outst_q, outst_d;
  logic [CNT_W-1:0]  drop_q, drop_d;
  logic              inst_valid_q;

  logic              pop_c;
  logic              resp_fire_c;
  logic              req_valid_c;
  logic              req_fire_c;
  logic              push_c;
  logic [SUM_W-1:0]  credit_sum_c;

  // Handshake qualifiers and the credit check that keeps the buffer from overflowing
  always_comb begin
    pop_c        = inst_valid_q & inst_ready;
    resp_fire_c  = imem_resp_valid & (outst_q != '0);
    credit_sum_c = SUM_W'(outst_q) + SUM_W'(count_q) - SUM_W'(pop_c);
    req_valid_c  = reset_n & ~redirect_valid & (credit_sum_c < SUM_W'(BUF_DEPTH));
    req_fire_c   = req_valid_c & imem_req_ready;
    push_c       = resp_fire_c & ~redirect_valid & (drop_q == '0);
  end

  // Next PC: redirect wins, then sequential advance on an accepted request, else hold
  always_comb begin
    next_pc = pc;
    if (!reset_n) begin
      next_pc = RESET_PC;
    end else if (redirect_valid) begin
      next_pc = redirect_pc;
    end else if (req_fire_c) begin
      next_pc = pc + ADDR_W'(1);
    end
  end

  // Next-state for pointers and counters; a redirect empties the buffer and marks in-flight reads stale
  always_comb begin
    af_wr_d = af_wr_q + PTR_W'(req_fire_c);
    af_rd_d = af_rd_q + PTR_W'(resp_fire_c);
    outst_d = outst_q + CNT_W'(req_fire_c) - CNT_W'(resp_fire_c);
    count_d = count_q;
    bf_rd_d = bf_rd_q;
    bf_wr_d = bf_wr_q;
    drop_d  = drop_q;
    if (redirect_valid) begin
      count_d = '0;
      bf_rd_d = bf_wr_q;
      drop_d  = outst_q - CNT_W'(resp_fire_c);
    end else begin
      count_d = count_q + CNT_W'(push_c) - CNT_W'(pop_c);
      bf_rd_d = bf_rd_q + PTR_W'(pop_c);
      bf_wr_d = bf_wr_q + PTR_W'(push_c);
      if (resp_fire_c && (drop_q != '0)) begin
        drop_d = drop_q - CNT_W'(1);
      end
    end
  end

  // Control state registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      af_wr_q      <= '0;
      af_rd_q      <= '0;
      bf_wr_q      <= '0;
      bf_rd_q      <= '0;
      count_q      <= '0;
      outst_q      <= '0;
      drop_q       <= '0;
      inst_valid_q <= 1'b0;
    end else begin
      af_wr_q      <= af_wr_d;
      af_rd_q      <= af_rd_d;
      bf_wr_q      <= bf_wr_d;
      bf_rd_q      <= bf_rd_d;
      count_q      <= count_d;
      outst_q      <= outst_d;
      drop_q       <= drop_d;
      inst_valid_q <= (count_d != '0);
    end
  end

  // Storage arrays: record request address on accept, capture {addr, data} on kept responses
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < int'(BUF_DEPTH); i++) begin
        afifo_q[i]    <= '0;
        buf_addr_q[i] <= '0;
        buf_data_q[i] <= '0;
      end
    end else begin
      if (req_fire_c) begin
        afifo_q[af_wr_q] <= pc;
      end
      if (push_c) begin
        buf_addr_q[bf_wr_q] <= afifo_q[af_rd_q];
        buf_data_q[bf_wr_q] <= imem_resp_data;
      end
    end
  end

  assign imem_req_valid = req_valid_c;
  assign imem_req_addr  = pc;
  assign inst_valid     = inst_valid_q;
  assign inst_data      = buf_data_q[bf_rd_q];
  assign inst_pc        = buf_addr_q[bf_rd_q];

`ifdef FETCH_PERF_EN
  logic [15:0] stall_q;
  logic [15:0] flush_q;

  // Saturating counters of request-idle cycles and redirects
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (!req_valid_c && (stall_q != 16'hFFFF)) begin
        stall_q <= stall_q + 16'd1;
      end
      if (redirect_valid && (flush_q != 16'hFFFF)) begin
        flush_q <= flush_q + 16'd1;
      end
    end
  end

  assign perf_stall_cycles = stall_q;
  assign perf_flushes      = flush_q;
`endif

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch front end: the reader of the 16-bit program counter register. It issues instruction-memory reads at the current PC and generates the next_pc value the PC register loads every cycle. Fetched words are buffered in order and handed to decode with a valid/ready handshake. It accepts branch/jump redirects from execute, flushing buffered and in-flight fetches.

## Interface
- ADDR_W, 16, PC and memory address width (word addressed)
- DATA_W, 16, instruction width
- BUF_DEPTH, 4, instruction buffer entries; power of two, ≥2
- RESET_PC, 16'h0000, next_pc value driven while in reset
- clk  in  1  clock, all state on rising edge
- reset_n  in  1  asynchronous active-low reset
- pc  in  ADDR_W  current PC register value
- next_pc  out  ADDR_W  combinational; loaded into PC each cycle
- redirect_valid  in  1  branch/jump taken this cycle
- redirect_pc  in  ADDR_W  redirect target
- imem_req_valid  out  1  read request
- imem_req_addr  out  ADDR_W  read address (= pc)
- imem_req_ready  in  1  memory accepts request
- imem_resp_valid  in  1  read data returned (in order, ≥1 cycle after accept)
- imem_resp_data  in  DATA_W  read data
- inst_valid  out  1  instruction available to decode
- inst_data  out  DATA_W  instruction word
- inst_pc  out  ADDR_W  address of inst_data
- inst_ready  in  1  decode accepts instruction

## Operation
- Storage: instruction buffer (BUF_DEPTH × {addr, data}), address FIFO (BUF_DEPTH) of outstanding request addresses, outstanding counter, drop counter.
- Credit rule: imem_req_valid = !redirect_valid && (outstanding + count − pop) < BUF_DEPTH, where pop = inst_valid && inst_ready. Response can therefore never overflow the buffer.
- Request accepted (valid && ready): push pc to address FIFO, outstanding+1.
- next_pc priority: redirect_valid → redirect_pc; request accepted → pc + 1 (wraps 16'hFFFF → 16'h0000); else pc (hold).
- Response, drop counter = 0: pop address FIFO, push {addr, data} into buffer, outstanding−1.
- Response, drop counter > 0: discard, pop address FIFO, drop−1, outstanding−1.
- Redirect: buffer emptied; drop counter ← outstanding minus any response arriving that cycle; a response arriving that cycle is discarded; requests suppressed for that cycle.
- Handshake completing in a redirect cycle counts as delivered (decode squashes).
- Buffer output registered: inst_valid = count ≠ 0, inst_data/inst_pc = head entry; stable while inst_valid && !inst_ready.
- imem_resp_valid with outstanding = 0: ignored, no state change.

## Timing
- Reset (reset_n low, async): count, outstanding, drop, FIFO pointers = 0; inst_valid = 0, inst_data = 0, inst_pc = 0; imem_req_valid = 0; next_pc = RESET_PC.
- First request in first cycle after reset_n deasserts (addr = pc).
- Request accepted cycle N, response cycle N+L → inst_valid cycle N+L+1.
- Redirect cycle R: PC = redirect_pc at R+1, first new request at R+1, inst_valid earliest R+L+2.
- Sustained 1 instruction/cycle when BUF_DEPTH ≥ L+1 and inst_ready held high.
- Simultaneous push and pop on full buffer allowed; count unchanged.
- Reset mid-operation: all in-flight fetches forgotten; memory must also be reset.

## Configuration
- FETCH_PERF_EN defined: adds outputs perf_stall_cycles (16) and perf_flushes (16); stall counter increments each cycle imem_req_valid = 0 outside reset, flush counter each redirect_valid; both saturate at 16'hFFFF, reset to 0.
- Undefined: ports and counters absent; behaviour otherwise identical.

## Test plan
- Reset, L=1, ready always high, pc from PC register: inst_pc 0,1,2,3… on consecutive cycles, first inst_valid two cycles after reset release.
- inst_ready low 10 cycles: exactly BUF_DEPTH entries buffered, imem_req_valid low, next_pc = pc held; release → in-order drain, no loss.
- L=3, two requests outstanding, redirect_pc = 16'h0100: both stale responses dropped, next inst_pc = 16'h0100, inst_valid low in between.
- imem_req_ready low 5 cycles at pc = 16'h0007: next_pc stays 16'h0007, no address skipped afterwards.
- pc = 16'hFFFF accepted: next_pc = 16'h0000, inst_pc 16'hFFFF then 16'h0000.
- reset_n asserted with full buffer: inst_valid and imem_req_valid drop asynchronously, next_pc = RESET_PC.
